cp0_intc: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core. It holds Status, Cause, EPC, Count and Compare, and services `mfc0`/`mtc0`. It samples external interrupt lines into Cause.IP, gates them against Status.IM/IE to raise `int_req`, and keeps a nested-exception stack of saved IE bits and EPC values so that `eret` unwinds one level at a time. It sits beside the decode/writeback stages; the core's exception logic consumes `int_req`, `status` and `exc_addr`.

---
 rtl/cp0_intc.sv | 162 ++++++++++++++++
 tb/tb_cp0_intc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// cp0_intc: MIPS coprocessor 0 with interrupt gating and a nested-exception stack.
//
// Holds Status, Cause, EPC (top of a NEST_DEPTH-deep IE/EPC stack), Count and
// Compare. Services mfc0 (combinational read) and mtc0 (registered write),
// samples the irq lines into Cause.IP and raises int_req when an enabled
// interrupt is pending.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   mfc0, rd_addr   : read enable and CP0 register number -> rdata
//   mtc0, wdata     : write wdata to register rd_addr
//   pc              : PC saved on exception
//   exception,
//   exc_code        : take an exception this cycle with the given ExcCode
//   eret            : return from exception (pops one stack level)
//   irq             : level-sensitive external interrupt lines
//   status          : current Status register
//   exc_addr        : top-of-stack EPC + 4
//   int_req         : an enabled interrupt is pending
//   nest_overflow   : sticky, set when a push occurs with the stack full
module cp0_intc #(
  parameter int NUM_IRQ    = 5,
  parameter int NEST_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [4:0]         rd_addr,
  input  logic [31:0]        wdata,
  input  logic [31:0]        pc,
  input  logic               exception,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        status,
  output logic [31:0]        exc_addr,
  output logic               int_req,
  output logic               nest_overflow
);

  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(NEST_DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic               ie;
  logic [7:0]         im;
  logic [4:0]         code_q;
  logic [1:0]         sw_ip;
  logic [NUM_IRQ-1:0] hw_ip;
  logic               ti;
  logic [31:0]        count, compare;
  logic [31:0]        epc_stk [NEST_DEPTH];
  logic               ie_stk  [NEST_DEPTH];
  logic [DW-1:0]      depth;

  logic [7:0]  ip;
  logic [31:0] cause;

  // IP[1:0] software, IP[2 +: NUM_IRQ] hardware lines, IP[7] timer.
  always_comb begin
    ip               = '0;
    ip[1:0]          = sw_ip;
    ip[2 +: NUM_IRQ] = hw_ip;
    ip[7]            = ti;
  end

  assign cause    = {16'h0, ip, 1'b0, code_q, 2'b00};
  assign status   = {16'h0, im, 7'h0, ie};
  assign exc_addr = epc_stk[0] + 32'd4;
  assign int_req  = ie & (|(ip & im));

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      unique case (rd_addr)
        A_COUNT:   rdata = count;
        A_COMPARE: rdata = compare;
        A_STATUS:  rdata = status;
        A_CAUSE:   rdata = cause;
        A_EPC:     rdata = epc_stk[0];
        default:   rdata = '0;
      endcase
    end
  end

  logic wr_cnt, wr_cmp, wr_sts, wr_cau, wr_epc, do_pop;
  assign wr_cnt = mtc0 && (rd_addr == A_COUNT);
  assign wr_cmp = mtc0 && (rd_addr == A_COMPARE);
  assign wr_sts = mtc0 && (rd_addr == A_STATUS);
  assign wr_cau = mtc0 && (rd_addr == A_CAUSE);
  assign wr_epc = mtc0 && (rd_addr == A_EPC);
  assign do_pop = eret && !exception && (depth != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ie            <= 1'b0;
      im            <= '0;
      code_q        <= '0;
      sw_ip         <= '0;
      hw_ip         <= '0;
      ti            <= 1'b0;
      count         <= '0;
      compare       <= 32'hFFFF_FFFF;
      depth         <= '0;
      nest_overflow <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        epc_stk[i] <= '0;
        ie_stk[i]  <= 1'b0;
      end
    end else begin
      hw_ip <= irq;

      // Count/Compare writes are independent of exception/eret.
      count <= wr_cnt ? wdata : count + 32'd1;
      if (wr_cmp) compare <= wdata;
      if (wr_cmp)                  ti <= 1'b0;
      else if (count == compare)   ti <= 1'b1;

      if (exception) begin
        // Push: index 0 is the top; the oldest entry falls off the bottom.
        for (int i = 1; i < NEST_DEPTH; i++) begin
          epc_stk[i] <= epc_stk[i-1];
          ie_stk[i]  <= ie_stk[i-1];
        end
        epc_stk[0] <= pc;
        ie_stk[0]  <= ie;
        ie         <= 1'b0;
        code_q     <= exc_code;
        if (depth == FULL) nest_overflow <= 1'b1;
        else               depth <= depth + ONE;
      end else if (do_pop) begin
        ie <= ie_stk[0];
        for (int i = 0; i < NEST_DEPTH - 1; i++) begin
          epc_stk[i] <= epc_stk[i+1];
          ie_stk[i]  <= ie_stk[i+1];
        end
        epc_stk[NEST_DEPTH-1] <= '0;
        ie_stk[NEST_DEPTH-1]  <= 1'b0;
        // An EPC written while the stack was empty can sit below the only
        // entry; emptying the stack must still leave EPC at 0.
        if (depth == ONE) epc_stk[0] <= '0;
        depth <= depth - ONE;
      end else if (!eret) begin
        if (wr_sts) begin
          ie <= wdata[0];
          im <= wdata[15:8];
        end
        if (wr_cau) sw_ip <= wdata[9:8];
        if (wr_epc) epc_stk[0] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
module tb_cp0_intc;

  localparam int NI = 5;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mfc0, mtc0, exception, eret;
  logic [4:0]    rd_addr, exc_code;
  logic [31:0]   wdata, pc;
  logic [NI-1:0] irq;
  logic [31:0]   rdata, status, exc_addr;
  logic          int_req, nest_overflow;

  int n_cmp = 0;
  int n_err = 0;

  cp0_intc #(.NUM_IRQ(NI), .NEST_DEPTH(ND)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .rd_addr(rd_addr),
    .wdata(wdata), .pc(pc), .exception(exception), .exc_code(exc_code),
    .eret(eret), .irq(irq), .rdata(rdata), .status(status),
    .exc_addr(exc_addr), .int_req(int_req), .nest_overflow(nest_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_ie, m_ti, m_ovf;
  bit [7:0]    m_im;
  bit [4:0]    m_code;
  bit [1:0]    m_sw;
  bit [NI-1:0] m_hw;
  bit [31:0]   m_cnt, m_cmp, m_epc0;
  bit [31:0]   epcq[$];
  bit          ieq[$];

  function automatic bit [31:0] m_cause();
    return {16'h0, m_ti, m_hw, m_sw, 1'b0, m_code, 2'b00};
  endfunction
  function automatic bit [31:0] m_status();
    return {16'h0, m_im, 7'h0, m_ie};
  endfunction
  function automatic bit [31:0] m_epc();
    return (epcq.size() > 0) ? epcq[0] : m_epc0;
  endfunction
  function automatic bit [31:0] m_read(bit en, bit [4:0] a);
    if (!en) return 0;
    case (a)
      5'd9:    return m_cnt;
      5'd11:   return m_cmp;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc();
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_ie = 0; m_ti = 0; m_ovf = 0; m_im = 0; m_code = 0; m_sw = 0; m_hw = 0;
    m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_epc0 = 0;
    epcq.delete(); ieq.delete();
  endtask

  task automatic m_step();
    bit match;
    if (rst) begin m_reset(); return; end
    match = (m_cnt == m_cmp);
    m_cnt = (mtc0 && rd_addr == 9) ? wdata : m_cnt + 1;
    if (mtc0 && rd_addr == 11) begin m_cmp = wdata; m_ti = 0; end
    else if (match) m_ti = 1;
    if (exception) begin
      ieq.push_front(m_ie);
      epcq.push_front(pc);
      if (epcq.size() > ND) begin
        void'(epcq.pop_back()); void'(ieq.pop_back()); m_ovf = 1;
      end
      m_ie = 0; m_code = exc_code;
    end else if (eret) begin
      if (epcq.size() > 0) begin
        m_ie = ieq.pop_front();
        void'(epcq.pop_front());
        if (epcq.size() == 0) m_epc0 = 0;
      end
    end else if (mtc0) begin
      case (rd_addr)
        5'd12: begin m_ie = wdata[0]; m_im = wdata[15:8]; end
        5'd13: m_sw = wdata[9:8];
        5'd14: if (epcq.size() > 0) epcq[0] = wdata; else m_epc0 = wdata;
        default: ;
      endcase
    end
    m_hw = irq;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit [31:0] c;
    c = m_cause();
    chk("rdata", rdata, m_read(mfc0, rd_addr));
    chk("status", status, m_status());
    chk("exc_addr", exc_addr, m_epc() + 32'd4);
    chk("int_req", {31'h0, int_req}, {31'h0, m_ie & (|(c[15:8] & m_im))});
    chk("nest_overflow", {31'h0, nest_overflow}, {31'h0, m_ovf});
  endtask

  // One cycle: inputs already driven; check, clock, update model, clear pulses.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
    mfc0 = 0; mtc0 = 0; exception = 0; eret = 0; rd_addr = 0; wdata = 0;
    pc = 0; exc_code = 0; rst = 0;
  endtask

  task automatic wr(bit [4:0] a, bit [31:0] d);
    mtc0 = 1; rd_addr = a; wdata = d; tick();
  endtask
  task automatic exc(bit [31:0] p, bit [4:0] c);
    exception = 1; pc = p; exc_code = c; tick();
  endtask
  task automatic ret();
    eret = 1; tick();
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin mfc0 = 1; rd_addr = 5'd9; tick(); end
  endtask
  task automatic rd_lit(string nm, bit [4:0] a, bit [31:0] mask, bit [31:0] exp);
    mfc0 = 1; rd_addr = a; #1 chk(nm, rdata & mask, exp);
    tick();
  endtask

  initial begin
    mfc0 = 0; mtc0 = 0; exception = 0; eret = 0; rd_addr = 0; wdata = 0;
    pc = 0; exc_code = 0; irq = '0; rst = 1;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    // reset held: outputs at reset values
    rst = 1; #1;
    chk("rst_exc_addr", exc_addr, 32'h4);
    chk("rst_int_req", {31'h0, int_req}, 32'h0);
    rst = 1; tick();

    // interrupt path
    wr(5'd12, 32'h0000_0401);
    irq = 5'b00001; tick();
    #1 chk("int_req_irq0", {31'h0, int_req}, 32'h1);
    rd_lit("cause_irq0", 5'd13, 32'hFFFF_FFFF, 32'h0000_0400);
    irq = '0; idle(1);

    // three nested exceptions, unwind
    exc(32'h100, 5'd0); exc(32'h200, 5'd8); exc(32'h300, 5'd9);
    #1 chk("nest_top", exc_addr, 32'h304);
    rd_lit("cause_code9", 5'd13, 32'h7C, 32'h24);
    ret(); #1 chk("eret1", exc_addr, 32'h204);
    ret(); #1 chk("eret2", exc_addr, 32'h104);
    chk("eret2_ie", status, 32'h400);
    ret(); #1 chk("eret3", exc_addr, 32'h4);
    chk("eret3_ie", status, 32'h401);
    ret(); #1 chk("eret4_noop", status, 32'h401);
    chk("eret4_addr", exc_addr, 32'h4);

    // overflow
    exc(32'h10, 5'd1); exc(32'h20, 5'd2); exc(32'h30, 5'd3); exc(32'h40, 5'd4);
    #1 chk("ovf_set", {31'h0, nest_overflow}, 32'h1);
    ret(); ret(); ret();
    rd_lit("ovf_epc0", 5'd14, 32'hFFFF_FFFF, 32'h0);
    #1 chk("ovf_sticky", {31'h0, nest_overflow}, 32'h1);

    // Cause write touches only IP[9:8]; EPC write hits top only
    wr(5'd13, 32'hFFFF_FFFF);
    exc(32'h700, 5'd5); wr(5'd14, 32'hABC0);
    #1 chk("epc_write", exc_addr, 32'hABC4);
    ret(); #1 chk("epc_pop_empty", exc_addr, 32'h4);
    wr(5'd13, 32'h0);

    // timer
    wr(5'd9, 32'h10); wr(5'd11, 32'h12);
    idle(1);
    rd_lit("ti_before", 5'd13, 32'h8000, 32'h0);
    rd_lit("ti_set", 5'd13, 32'h8000, 32'h8000);
    wr(5'd9, 32'hFFFF_FFFF);
    rd_lit("cnt_max", 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_lit("cnt_wrap", 5'd9, 32'hFFFF_FFFF, 32'h0);
    wr(5'd11, 32'h60); wr(5'd9, 32'h5E); idle(2);
    wr(5'd11, 32'h90);   // count == compare this cycle
    rd_lit("ti_clear_wins", 5'd13, 32'h8000, 32'h0);

    // exception + eret + mtc0 Status in one cycle
    wr(5'd12, 32'h1);
    exception = 1; pc = 32'h500; exc_code = 5'd4; eret = 1;
    mtc0 = 1; rd_addr = 5'd12; wdata = 32'hFF01; tick();
    #1 chk("simul_status", status, 32'h0);
    chk("simul_addr", exc_addr, 32'h504);

    // reset mid-nesting
    exc(32'h600, 5'd6);
    rst = 1; tick();
    #1 chk("rst_mid_addr", exc_addr, 32'h4);
    chk("rst_mid_ovf", {31'h0, nest_overflow}, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
